// File: rtl/inbuf_stream_loader_pkg.sv
// Shared constants and FSM encoding for the input frame buffer loader.
package inbuf_stream_loader_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 17;
  localparam int WIDTH  = 480;
  localparam int HEIGHT = 272;
  localparam int DEPTH  = WIDTH * HEIGHT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/inbuf_stream_loader.sv
// Writer side of the input frame buffer: takes an RGB888 valid/ready stream
// with SOF/EOL markers and writes one frame into the inbuf BRAM in raster
// order, then pulses oStart and holds until the reader releases the buffer.
module inbuf_stream_loader #(
  parameter int DATA_W = inbuf_stream_loader_pkg::DATA_W,
  parameter int ADDR_W = inbuf_stream_loader_pkg::ADDR_W,
  parameter int WIDTH  = inbuf_stream_loader_pkg::WIDTH,
  parameter int HEIGHT = inbuf_stream_loader_pkg::HEIGHT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iData,
  input  logic              iSof,
  input  logic              iEol,
  input  logic              iRelease,
  output logic              oCs,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic              oStart,
  output logic              oErr
);
  import inbuf_stream_loader_pkg::*;

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;   // running raster address, tracks row*WIDTH+col

  logic accept;
  logic colLast;
  logic rowLast;

  assign accept  = iValid & oReady;
  assign colLast = (col == COL_LAST);
  assign rowLast = (row == ROW_LAST);

  // Frame FSM, position counters and all registered BRAM/handshake outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= ST_IDLE;
      oReady  <= 1'b0;
      oCs     <= 1'b0;
      oWe     <= 1'b0;
      oAddr   <= '0;
      oWrData <= '0;
      oStart  <= 1'b0;
      oErr    <= 1'b0;
      col     <= '0;
      row     <= '0;
      addr    <= '0;
    end else begin
      // write strobe and start pulse are single-cycle unless re-asserted below
      oCs    <= 1'b0;
      oWe    <= 1'b0;
      oStart <= 1'b0;
      case (state)
        ST_IDLE: begin
          oReady <= 1'b1;
          col    <= '0;
          row    <= '0;
          addr   <= '0;
          if (accept && iSof) begin
            oCs     <= 1'b1;
            oWe     <= 1'b1;
            oAddr   <= '0;
            oWrData <= iData;
            col     <= COL_ONE;
            addr    <= ADDR_ONE;
            state   <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          oReady <= 1'b1;
          if (!accept) begin
            state <= ST_LOAD;
          end else if (iSof) begin
            // unexpected SOF: flag it and restart the frame on this beat
            oErr    <= 1'b1;
            oCs     <= 1'b1;
            oWe     <= 1'b1;
            oAddr   <= '0;
            oWrData <= iData;
            col     <= COL_ONE;
            row     <= '0;
            addr    <= ADDR_ONE;
            state   <= ST_LOAD;
          end else if (iEol != colLast) begin
            // EOL misplaced or missing: drop the beat and the partial frame
            oErr  <= 1'b1;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
            state <= ST_IDLE;
          end else begin
            oCs     <= 1'b1;
            oWe     <= 1'b1;
            oAddr   <= addr;
            oWrData <= iData;
            if (colLast) begin
              col <= '0;
              if (rowLast) begin
                row    <= '0;
                addr   <= '0;
                oReady <= 1'b0;
                state  <= ST_DONE;
              end else begin
                row   <= row + ROW_ONE;
                addr  <= addr + ADDR_ONE;
                state <= ST_LOAD;
              end
            end else begin
              col   <= col + COL_ONE;
              addr  <= addr + ADDR_ONE;
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          oReady <= 1'b0;
          oStart <= 1'b1;
          state  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (iRelease) begin
            oReady <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            oReady <= 1'b0;
            state  <= ST_HOLD;
          end
        end
        default: begin
          oReady <= 1'b0;
          col    <= '0;
          row    <= '0;
          addr   <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
